// File: rtl/clock_time_setter.sv
// rtl/clock_time_setter.sv - HH:MM:SS timekeeper with button set mode and 7-segment digit outputs
module clock_time_setter #(
    parameter int TICK_DIV  = 1000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       inc,
    output logic [6:0] data1,
    output logic [6:0] data2,
    output logic [6:0] data3,
    output logic [6:0] data4,
    output logic [6:0] data5,
    output logic [6:0] data6,
    output logic       h,
    output logic       m,
    output logic       s
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

    state_t        state;
    logic [7:0]    hr, mn, sc;      // packed BCD {tens, ones}
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            hr          <= 8'h00;
            mn          <= 8'h00;
            sc          <= 8'h00;
            presc       <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            // Any accepted press restarts the blink so the field stays visible.
            if (mode || (inc && state != RUN)) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            case (state)
                RUN: begin
                    if (presc == TICK_MAX) begin
                        presc <= '0;
                        sc    <= bcd_inc(sc, 8'h59);
                        if (sc == 8'h59)
                            mn <= bcd_inc(mn, 8'h59);
                        if (sc == 8'h59 && mn == 8'h59)
                            hr <= bcd_inc(hr, 8'h23);
                    end else begin
                        presc <= presc + 1'b1;
                    end
                    if (mode)
                        state <= SET_H;
                end
                SET_H: begin
                    presc <= '0;
                    if (mode)
                        state <= SET_M;
                    else if (inc)
                        hr <= bcd_inc(hr, 8'h23);
                end
                SET_M: begin
                    presc <= '0;
                    if (mode)
                        state <= SET_S;
                    else if (inc)
                        mn <= bcd_inc(mn, 8'h59);
                end
                SET_S: begin
                    presc <= '0;
                    if (mode)
                        state <= RUN;
                    else if (inc)
                        sc <= bcd_inc(sc, 8'h59);
                end
                default: state <= RUN;
            endcase
        end
    end

    assign data1 = seg7(hr[7:4]);
    assign data2 = seg7(hr[3:0]);
    assign data3 = seg7(mn[7:4]);
    assign data4 = seg7(mn[3:0]);
    assign data5 = seg7(sc[7:4]);
    assign data6 = seg7(sc[3:0]);

    assign h = (state == SET_H) && blink_phase;
    assign m = (state == SET_M) && blink_phase;
    assign s = (state == SET_S) && blink_phase;
endmodule

// File: tb/tb_clock_time_setter.sv
// tb/tb_clock_time_setter.sv - directed scoreboard bench for clock_time_setter
module tb_clock_time_setter;
    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic       inc;
    logic [6:0] data1, data2, data3, data4, data5, data6;
    logic       h, m, s;

    typedef struct {
        string       tag;
        logic [44:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    clock_time_setter #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
        .clock(clock), .reset(reset), .mode(mode), .inc(inc),
        .data1(data1), .data2(data2), .data3(data3),
        .data4(data4), .data5(data5), .data6(data6),
        .h(h), .m(m), .s(s)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int hh, input int mm, input int ss,
                            input logic eh, input logic em, input logic es);
        exp_t e;
        e.tag = tag;
        e.exp = {seg(hh / 10), seg(hh % 10), seg(mm / 10), seg(mm % 10),
                 seg(ss / 10), seg(ss % 10), eh, em, es};
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [44:0] obs;
        obs = {data1, data2, data3, data4, data5, data6, h, m, s};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic pm, input logic pi);
        mode = pm;
        inc  = pi;
        step(1);
        mode = 1'b0;
        inc  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        inc   = 1'b0;
        push_exp("reset_state", 0, 0, 0, 0, 0, 0);
        step(2);
        check_out();
        reset = 1'b0;

        // 1: free run, 4 cycles per second
        push_exp("run_59s", 0, 0, 59, 0, 0, 0);
        step(236);
        check_out();
        push_exp("run_1min", 0, 1, 0, 0, 0, 0);
        step(4);
        check_out();

        // 2: preload 23:59:59 and roll over
        press(1, 0);
        for (int i = 0; i < 23; i++) press(0, 1);
        push_exp("set_hours_23", 23, 1, 0, 0, 0, 0);
        check_out();
        press(1, 0);
        for (int i = 0; i < 58; i++) press(0, 1);
        press(1, 0);
        for (int i = 0; i < 59; i++) press(0, 1);
        push_exp("preload_235959", 23, 59, 59, 0, 0, 0);
        check_out();
        press(1, 0);
        push_exp("run_hold_3cyc", 23, 59, 59, 0, 0, 0);
        step(3);
        check_out();
        push_exp("rollover_000000", 0, 0, 0, 0, 0, 0);
        step(1);
        check_out();

        // 3: hours wrap without carry, time frozen
        press(1, 0);
        for (int i = 0; i < 25; i++) press(0, 1);
        push_exp("hours_inc25", 1, 0, 0, 0, 0, 0);
        check_out();
        push_exp("frozen_100cyc", 1, 0, 0, ((100 / 3) % 2) == 1, 0, 0);
        step(100);
        check_out();

        // 4: minutes wrap without carry, blink pattern
        press(1, 0);
        for (int i = 0; i < 59; i++) press(0, 1);
        push_exp("minutes_59", 1, 59, 0, 0, 0, 0);
        check_out();
        press(0, 1);
        push_exp("min_wrap_k0", 1, 0, 0, 0, 0, 0);
        check_out();
        for (int k = 1; k < 9; k++) begin
            push_exp($sformatf("blink_m_k%0d", k), 1, 0, 0, 0, ((k / 3) % 2) == 1, 0);
            step(1);
            check_out();
        end

        // 5: mode beats inc in SET_S
        press(1, 0);
        for (int i = 0; i < 5; i++) press(0, 1);
        press(1, 1);
        push_exp("mode_wins", 1, 0, 5, 0, 0, 0);
        check_out();
        push_exp("first_tick_pre", 1, 0, 5, 0, 0, 0);
        step(3);
        check_out();
        push_exp("first_tick", 1, 0, 6, 0, 0, 0);
        step(1);
        check_out();

        // 6: asynchronous reset mid-SET_M with blink_phase high
        press(1, 0);
        press(1, 0);
        push_exp("set_m_blink_on", 1, 0, 6, 0, 1, 0);
        step(3);
        check_out();
        #2;
        reset = 1'b1;
        push_exp("async_reset", 0, 0, 0, 0, 0, 0);
        #1;
        check_out();
        @(posedge clock);
        #1;
        reset = 1'b0;
        push_exp("post_reset_run", 0, 0, 0, 0, 0, 0);
        step(3);
        check_out();
        push_exp("post_reset_tick", 0, 0, 1, 0, 0, 0);
        step(1);
        check_out();

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
